// File: rtl/tight_acc_pkg.sv
// Shared types for the tightly-coupled accelerator command issuer.
package tight_acc_pkg;

    localparam int OPCODE_W = 6;
    localparam int DATA_W   = 64;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RESP
    } issuer_state_e;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [DATA_W-1:0]   data;
        logic                expect_resp;
    } cmd_entry_t;

    typedef struct packed {
        logic              timeout;
        logic [DATA_W-1:0] data;
    } resp_entry_t;

endpackage

// File: rtl/tight_acc_fifo.sv
// Synchronous FIFO with registered storage; head entry is presented on rd_data.
module tight_acc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is refused even if the head pops in the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/tight_acc_cmd_issuer.sv
// Core-side master: queues commands, issues one at a time to the accelerator,
// and returns responses (or timeout markers) to the core in command order.
//
// state     | meaning
// IDLE      | waiting for a queued command (and response room if it needs one)
// ISSUE     | acc_cmd_val high, payload held until the accelerator accepts
// WAIT_RESP | one command outstanding, timer running until response or timeout
module tight_acc_cmd_issuer
    import tight_acc_pkg::*;
#(
    parameter int CMD_DEPTH      = 4,
    parameter int RESP_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                core_cmd_val,
    output logic                core_cmd_rdy,
    input  logic [OPCODE_W-1:0] core_cmd_opcode,
    input  logic [DATA_W-1:0]   core_cmd_data,
    input  logic                core_cmd_expect_resp,
    output logic                core_resp_val,
    input  logic                core_resp_rdy,
    output logic [DATA_W-1:0]   core_resp_data,
    output logic                core_resp_timeout,
    output logic                acc_cmd_val,
    input  logic                acc_busy,
    output logic [OPCODE_W-1:0] acc_cmd_opcode,
    output logic [DATA_W-1:0]   acc_cmd_config_data,
    input  logic                acc_resp_val,
    output logic                acc_resp_rdy,
    input  logic [DATA_W-1:0]   acc_resp_data,
    output logic                outstanding,
    output logic                err_timeout,
    output logic                err_spurious,
    input  logic                err_clr,
    output logic [CNT_W-1:0]    issued_cnt
);

    localparam int CMD_AW  = $clog2(CMD_DEPTH);
    localparam int RESP_AW = $clog2(RESP_DEPTH);

    issuer_state_e state, state_nxt;

    cmd_entry_t          cmd_in, cmd_head, iss_q;
    resp_entry_t         resp_in, resp_head;
    logic                cmd_full, cmd_empty, cmd_pop;
    logic                resp_full, resp_empty, resp_push, resp_pop;
    logic [CMD_AW:0]     cmd_count;
    logic [RESP_AW:0]    resp_count;
    logic [31:0]         timer;
    logic                timeout_hit;
    logic                accept;
    logic                unused_status;

    assign cmd_in = '{opcode: core_cmd_opcode, data: core_cmd_data,
                      expect_resp: core_cmd_expect_resp};

    tight_acc_fifo #(.WIDTH($bits(cmd_entry_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (core_cmd_val),
        .wr_data (cmd_in),
        .pop     (cmd_pop),
        .rd_data (cmd_head),
        .full    (cmd_full),
        .empty   (cmd_empty),
        .count   (cmd_count)
    );

    tight_acc_fifo #(.WIDTH($bits(resp_entry_t)), .DEPTH(RESP_DEPTH)) u_resp_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (resp_push),
        .wr_data (resp_in),
        .pop     (resp_pop),
        .rd_data (resp_head),
        .full    (resp_full),
        .empty   (resp_empty),
        .count   (resp_count)
    );

    assign unused_status = &{1'b0, cmd_count, resp_full};

    // Response room is reserved at issue time, so the later push can never overflow.
    assign cmd_pop = (state == IDLE) && !cmd_empty &&
                     (!cmd_head.expect_resp || resp_count < (RESP_AW+1)'(RESP_DEPTH));

    assign accept      = acc_cmd_val & ~acc_busy;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer == 32'(TIMEOUT_CYCLES - 1));
    assign resp_push   = (state == WAIT_RESP) && (acc_resp_val || timeout_hit);
    assign resp_in     = acc_resp_val ? '{timeout: 1'b0, data: acc_resp_data}
                                      : '{timeout: 1'b1, data: '0};
    assign resp_pop    = core_resp_val & core_resp_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (cmd_pop) state_nxt = ISSUE;
            ISSUE:     if (accept) state_nxt = iss_q.expect_resp ? WAIT_RESP : IDLE;
            WAIT_RESP: if (acc_resp_val || timeout_hit) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        acc_cmd_val  = 1'b0;
        acc_resp_rdy = 1'b0;
        outstanding  = 1'b0;
        case (state)
            ISSUE:     acc_cmd_val = 1'b1;
            WAIT_RESP: begin
                acc_resp_rdy = 1'b1;
                outstanding  = 1'b1;
            end
            default:   ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_q        <= '0;
            issued_cnt   <= '0;
            timer        <= '0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            if (cmd_pop) iss_q <= cmd_head;
            if (accept) issued_cnt <= issued_cnt + 1'b1;
            timer <= (state == WAIT_RESP) ? timer + 1'b1 : '0;
            // Set beats clear when both land in the same cycle.
            err_timeout  <= (resp_push & ~acc_resp_val) | (err_timeout & ~err_clr);
            err_spurious <= (acc_resp_val & (state != WAIT_RESP)) | (err_spurious & ~err_clr);
        end
    end

    assign core_cmd_rdy        = ~cmd_full;
    assign core_resp_val       = ~resp_empty;
    assign core_resp_data      = resp_head.data;
    assign core_resp_timeout   = resp_head.timeout;
    assign acc_cmd_opcode      = iss_q.opcode;
    assign acc_cmd_config_data = iss_q.data;

endmodule

// File: tb/tb_tight_acc_cmd_issuer.sv
// Directed bench for tight_acc_cmd_issuer with hand-computed expectations.
module tb_tight_acc_cmd_issuer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_cmd_val = 1'b0;
    logic        core_cmd_rdy;
    logic [5:0]  core_cmd_opcode = '0;
    logic [63:0] core_cmd_data = '0;
    logic        core_cmd_expect_resp = 1'b0;
    logic        core_resp_val;
    logic        core_resp_rdy = 1'b0;
    logic [63:0] core_resp_data;
    logic        core_resp_timeout;
    logic        acc_cmd_val;
    logic        acc_busy = 1'b1;
    logic [5:0]  acc_cmd_opcode;
    logic [63:0] acc_cmd_config_data;
    logic        acc_resp_val = 1'b0;
    logic        acc_resp_rdy;
    logic [63:0] acc_resp_data = '0;
    logic        outstanding;
    logic        err_timeout;
    logic        err_spurious;
    logic        err_clr = 1'b0;
    logic [15:0] issued_cnt;

    int errors = 0;
    int checks = 0;
    int acc_accepts = 0;

    tight_acc_cmd_issuer #(
        .CMD_DEPTH(4), .RESP_DEPTH(4), .TIMEOUT_CYCLES(8), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .core_cmd_val(core_cmd_val), .core_cmd_rdy(core_cmd_rdy),
        .core_cmd_opcode(core_cmd_opcode), .core_cmd_data(core_cmd_data),
        .core_cmd_expect_resp(core_cmd_expect_resp),
        .core_resp_val(core_resp_val), .core_resp_rdy(core_resp_rdy),
        .core_resp_data(core_resp_data), .core_resp_timeout(core_resp_timeout),
        .acc_cmd_val(acc_cmd_val), .acc_busy(acc_busy),
        .acc_cmd_opcode(acc_cmd_opcode), .acc_cmd_config_data(acc_cmd_config_data),
        .acc_resp_val(acc_resp_val), .acc_resp_rdy(acc_resp_rdy),
        .acc_resp_data(acc_resp_data),
        .outstanding(outstanding), .err_timeout(err_timeout),
        .err_spurious(err_spurious), .err_clr(err_clr), .issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && acc_cmd_val && !acc_busy) acc_accepts++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(input logic [5:0] op, input logic [63:0] data, input logic er);
        int n = 0;
        core_cmd_val = 1'b1;
        core_cmd_opcode = op;
        core_cmd_data = data;
        core_cmd_expect_resp = er;
        while (core_cmd_rdy !== 1'b1 && n < 60) begin tick(); n++; end
        chk("push_rdy", core_cmd_rdy, 64'd1);
        tick();
        core_cmd_val = 1'b0;
    endtask

    task automatic issue_and_accept(input logic [5:0] op, input logic [63:0] data);
        int n = 0;
        while (acc_cmd_val !== 1'b1 && n < 60) begin tick(); n++; end
        chk("issue_val", acc_cmd_val, 64'd1);
        chk("issue_op", acc_cmd_opcode, 64'(op));
        chk("issue_data", acc_cmd_config_data, data);
        acc_busy = 1'b0;
        tick();
        acc_busy = 1'b1;
        chk("issue_drop", acc_cmd_val, 64'd0);
    endtask

    task automatic respond(input logic [63:0] data);
        int n = 0;
        while (acc_resp_rdy !== 1'b1 && n < 60) begin tick(); n++; end
        chk("resp_rdy", acc_resp_rdy, 64'd1);
        acc_resp_val = 1'b1;
        acc_resp_data = data;
        tick();
        acc_resp_val = 1'b0;
    endtask

    task automatic pop_resp(input logic [63:0] data, input logic to);
        int n = 0;
        while (core_resp_val !== 1'b1 && n < 60) begin tick(); n++; end
        chk("pop_val", core_resp_val, 64'd1);
        chk("pop_data", core_resp_data, data);
        chk("pop_timeout", core_resp_timeout, 64'(to));
        core_resp_rdy = 1'b1;
        tick();
        core_resp_rdy = 1'b0;
    endtask

    initial begin
        int base;
        // Reset state
        #2;
        chk("rst_cmd_rdy", core_cmd_rdy, 64'd1);
        chk("rst_acc_val", acc_cmd_val, 64'd0);
        chk("rst_resp_val", core_resp_val, 64'd0);
        chk("rst_resp_data", core_resp_data, 64'd0);
        chk("rst_cnt", issued_cnt, 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // 1: single command, 2-cycle issue latency, response 3 cycles after accept
        acc_busy = 1'b0;
        core_cmd_val = 1'b1; core_cmd_opcode = 6'h01; core_cmd_data = 64'd144;
        core_cmd_expect_resp = 1'b1;
        tick();
        core_cmd_val = 1'b0;
        chk("t1_val_t1", acc_cmd_val, 64'd0);
        tick();
        chk("t1_val_t2", acc_cmd_val, 64'd1);
        chk("t1_op", acc_cmd_opcode, 64'h01);
        chk("t1_data", acc_cmd_config_data, 64'd144);
        tick();
        acc_busy = 1'b1;
        chk("t1_drop", acc_cmd_val, 64'd0);
        chk("t1_cnt", issued_cnt, 64'd1);
        chk("t1_outstanding", outstanding, 64'd1);
        tick(); tick();
        acc_resp_val = 1'b1; acc_resp_data = 64'd12;
        tick();
        acc_resp_val = 1'b0;
        chk("t1_outstanding_done", outstanding, 64'd0);
        chk("t1_accepts", acc_accepts, 64'd1);
        pop_resp(64'd12, 1'b0);
        chk("t1_empty", core_resp_val, 64'd0);

        // 2: busy stall for 5 cycles in ISSUE, no-response command
        push_cmd(6'h02, 64'hAAAA_5555_0000_1234, 1'b0);
        begin
            int n = 0;
            while (acc_cmd_val !== 1'b1 && n < 20) begin tick(); n++; end
        end
        base = acc_accepts;
        for (int i = 0; i < 5; i++) begin
            chk("t2_val", acc_cmd_val, 64'd1);
            chk("t2_op", acc_cmd_opcode, 64'h02);
            chk("t2_data", acc_cmd_config_data, 64'hAAAA_5555_0000_1234);
            chk("t2_no_accept", acc_accepts, 64'(base));
            tick();
        end
        acc_busy = 1'b0;
        tick();
        acc_busy = 1'b1;
        chk("t2_one_accept", acc_accepts, 64'(base + 1));
        chk("t2_drop", acc_cmd_val, 64'd0);
        chk("t2_no_wait", outstanding, 64'd0);
        tick();
        chk("t2_no_resp", core_resp_val, 64'd0);

        // 3: five commands with stalled accelerator fill the queue
        for (int i = 1; i <= 5; i++) push_cmd(6'(10 + i), 64'(i), 1'b1);
        chk("t3_full", core_cmd_rdy, 64'd0);
        for (int i = 1; i <= 5; i++) begin
            issue_and_accept(6'(10 + i), 64'(i));
            respond(64'(i));
            pop_resp(64'(i), 1'b0);
        end
        chk("t3_cnt", issued_cnt, 64'd7);

        // 4: timeout after 8 WAIT_RESP cycles
        push_cmd(6'd30, 64'h300, 1'b1);
        issue_and_accept(6'd30, 64'h300);
        for (int k = 0; k < 7; k++) begin
            chk("t4_waiting", outstanding, 64'd1);
            tick();
        end
        chk("t4_last_wait", outstanding, 64'd1);
        chk("t4_no_resp_yet", core_resp_val, 64'd0);
        tick();
        chk("t4_idle", outstanding, 64'd0);
        chk("t4_err", err_timeout, 64'd1);
        pop_resp(64'd0, 1'b1);
        push_cmd(6'd31, 64'h301, 1'b0);
        issue_and_accept(6'd31, 64'h301);
        chk("t4_sticky", err_timeout, 64'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t4_cleared", err_timeout, 64'd0);

        // 5: response FIFO full blocks the 5th issue
        for (int i = 1; i <= 4; i++) begin
            push_cmd(6'(20 + i), 64'(256 + i), 1'b1);
            issue_and_accept(6'(20 + i), 64'(256 + i));
            respond(64'(512 + i));
        end
        push_cmd(6'd25, 64'd261, 1'b1);
        push_cmd(6'd26, 64'd262, 1'b1);
        for (int k = 0; k < 5; k++) tick();
        chk("t5_blocked", acc_cmd_val, 64'd0);
        chk("t5_cnt", issued_cnt, 64'd13);
        pop_resp(64'd513, 1'b0);
        issue_and_accept(6'd25, 64'd261);
        respond(64'd517);
        pop_resp(64'd514, 1'b0);
        issue_and_accept(6'd26, 64'd262);
        respond(64'd518);
        pop_resp(64'd515, 1'b0);
        pop_resp(64'd516, 1'b0);
        pop_resp(64'd517, 1'b0);
        pop_resp(64'd518, 1'b0);
        chk("t5_drained", core_resp_val, 64'd0);
        chk("t5_cnt_end", issued_cnt, 64'd15);

        // 6: spurious response in IDLE, then reset mid-issue
        acc_resp_val = 1'b1; acc_resp_data = 64'hDEAD;
        tick();
        acc_resp_val = 1'b0;
        chk("t6_spurious", err_spurious, 64'd1);
        chk("t6_no_push", core_resp_val, 64'd0);
        push_cmd(6'd40, 64'h400, 1'b1);
        begin
            int n = 0;
            while (acc_cmd_val !== 1'b1 && n < 20) begin tick(); n++; end
        end
        chk("t6_in_issue", acc_cmd_val, 64'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_val", acc_cmd_val, 64'd0);
        chk("t6_rst_cnt", issued_cnt, 64'd0);
        chk("t6_rst_spur", err_spurious, 64'd0);
        chk("t6_rst_tmo", err_timeout, 64'd0);
        chk("t6_rst_rdy", core_cmd_rdy, 64'd1);
        chk("t6_rst_op", acc_cmd_opcode, 64'd0);
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("t6_post_val", acc_cmd_val, 64'd0);
        chk("t6_post_resp", core_resp_val, 64'd0);
        chk("t6_post_out", outstanding, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
